tawas_regfile: RTL
==================

TAWAS_REGFILE -- requirements
Module: tawas_regfile

Interface
REQ-001 Parameter AU_WB_LAT, default 2: cycles from AU operand read to AU writeback; legal values 1..3.
REQ-002 Reset rst, asynchronous, active-high; clock clk.
REQ-003 clk  in  1  core clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 slice  out  2  current hardware thread, free-running.
REQ-006 au_ra_sel  in  3  AU operand A register select.
REQ-007 au_ra  out  32  AU operand A data.
REQ-008 au_rb_sel  in  3  AU operand B register select.
REQ-009 au_rb  out  32  AU operand B data.
REQ-010 au_rc_vld  in  1  AU writeback strobe.
REQ-011 au_rc_sel  in  3  AU writeback register.
REQ-012 au_rc  in  32  AU writeback data.
REQ-013 ls_rd_sel  in  3  load/store read register (store data, address base).
REQ-014 ls_rd  out  32  load/store read data.
REQ-015 ls_wr_vld  in  1  load writeback request.
REQ-016 ls_wr_slice  in  2  load writeback target thread.
REQ-017 ls_wr_sel  in  3  load writeback register.
REQ-018 ls_wr_data  in  32  load writeback data.
REQ-019 ls_wr_rdy  out  1  load writeback accepted this cycle.

Function
REQ-020 Storage SHALL be 4 threads x 8 registers x 32 bits.
REQ-021 slice SHALL increment by 1 every cycle, wrapping 3->0.
REQ-022 au_ra, au_rb, ls_rd SHALL be combinational reads of thread = slice at their selects, zero added latency.
REQ-023 An AU write (au_rc_vld=1) SHALL update register au_rc_sel of thread (slice - AU_WB_LAT) mod 4 at the clock edge.
REQ-024 A load write SHALL occur only when ls_wr_vld=1 and ls_wr_rdy=1, updating register ls_wr_sel of thread ls_wr_slice at the clock edge.
REQ-025 ls_wr_rdy SHALL be 0 only when au_rc_vld=1 and the AU target thread and register both equal ls_wr_slice/ls_wr_sel; otherwise 1 (combinational).
REQ-026 On ls_wr_rdy=0 the load requester holds ls_wr_vld, ls_wr_slice, ls_wr_sel, ls_wr_data stable; the write completes on the first cycle rdy=1, no data loss.
REQ-027 AU and load writes to different thread/register in the same cycle SHALL both complete.
REQ-028 Read bypass: if an accepted load write targets thread = slice and register equal to a read select that cycle, that read port SHALL return ls_wr_data, not stored value.
REQ-029 AU writes SHALL never be bypassed to reads (target thread always differs from slice for AU_WB_LAT 1..3).
REQ-030 AU write and load write SHALL never stall reads or the slice counter.
REQ-031 ls_wr_vld=0 SHALL leave storage unchanged regardless of other load inputs.

Reset
REQ-032 While rst=1: slice=0, all 32 registers=0, so au_ra=au_rb=ls_rd=0; ls_wr_rdy follows REQ-025.
REQ-033 Writes presented during rst=1 SHALL be discarded.
REQ-034 Reset asserted mid-operation SHALL clear state on assertion without waiting for clk; first post-reset edge makes slice=1.

Verification
REQ-035 Release reset, sample 8 cycles -> slice 0,1,2,3,0,1,2,3; all reads 0.
REQ-036 AU_WB_LAT=2: au_rc_vld=1, au_rc_sel=5, au_rc=0xDEADBEEF at slice=3 -> next time slice=1, au_ra_sel=5 reads 0xDEADBEEF; threads 0,2,3 r5 still 0.
REQ-037 At slice=0, au_rc_vld=1, au_rc_sel=2 and ls_wr_vld=1, ls_wr_slice=2, ls_wr_sel=2, ls_wr_data=0x55 -> ls_wr_rdy=0, thread2 r2 = AU data; next cycle rdy=1, thread2 r2=0x55 after that edge.
REQ-038 At slice=1, ls_wr_vld=1, ls_wr_slice=1, ls_wr_sel=4, ls_wr_data=0x1234, au_rb_sel=4 -> au_rb=0x1234 same cycle; stored value 0x1234 thereafter.
REQ-039 Same-cycle AU write thread3 r1=0xA and load write thread0 r7=0xB -> both registers updated, ls_wr_rdy=1.
REQ-040 Write all 32 registers with distinct values, assert rst for under one clk period between edges -> all reads 0, slice=0 immediately.

Source files
------------

// File: rtl/tawas_regfile.sv
// tawas_regfile: barrel-threaded register file for the Tawas core.
// Four hardware threads share one datapath; the active thread (slice)
// rotates every cycle. Each thread owns eight 32-bit registers. The AU
// reads operands for the current slice and writes back AU_WB_LAT cycles
// later. The load/store unit reads for the current slice and writes load
// results to any thread through a ready/valid port.
//
// AU_WB_LAT must be 1..3. With four threads this guarantees that the AU
// writeback thread never equals the current slice. AU results therefore
// never need a bypass onto the read ports.

module tawas_regfile #(
   parameter int AU_WB_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,

   output logic [1:0]  slice,

   input  logic [2:0]  au_ra_sel,
   output logic [31:0] au_ra,
   input  logic [2:0]  au_rb_sel,
   output logic [31:0] au_rb,
   input  logic        au_rc_vld,
   input  logic [2:0]  au_rc_sel,
   input  logic [31:0] au_rc,

   input  logic [2:0]  ls_rd_sel,
   output logic [31:0] ls_rd,
   input  logic        ls_wr_vld,
   input  logic [1:0]  ls_wr_slice,
   input  logic [2:0]  ls_wr_sel,
   input  logic [31:0] ls_wr_data,
   output logic        ls_wr_rdy
);

   localparam int         NUM_THREADS = 4;
   localparam int         NUM_REGS    = 8;
   localparam int         DATA_W      = 32;
   localparam logic [1:0] AU_LAT      = 2'(AU_WB_LAT);

   // Active thread counter.
   logic [1:0] slice_q;

   // Register storage, indexed [thread][register].
   logic [DATA_W-1:0] regs_q [NUM_THREADS][NUM_REGS];

   // Registers of the thread currently in the read slot.
   logic [DATA_W-1:0] thread_row [NUM_REGS];

   // Write path.
   logic [1:0]                          au_wb_slice;
   logic                                au_ls_conflict;
   logic                                ls_wr_en;
   logic [NUM_THREADS-1:0][NUM_REGS-1:0] au_we;
   logic [NUM_THREADS-1:0][NUM_REGS-1:0] ls_we;

   // Read path.
   logic ra_hit;
   logic rb_hit;
   logic ld_hit;

   // Select the forwarded load data when the read hits the accepted load write.
   function automatic logic [DATA_W-1:0] bypass_mux(
      input logic [DATA_W-1:0] stored,
      input logic              hit,
      input logic [DATA_W-1:0] fwd
   );
      return hit ? fwd : stored;
   endfunction

   // ------------------------------------------------------------------
   // Thread rotation
   // ------------------------------------------------------------------

   // Free-running slice counter; wraps 3 -> 0 by natural 2-bit overflow.
   // NOTE: state uses non-blocking assignments, so every flop samples
   // pre-edge values and the result does not depend on process order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slice_q <= 2'd0;
      end else begin
         slice_q <= slice_q + 2'd1;
      end
   end

   assign slice = slice_q;

   // ------------------------------------------------------------------
   // Write arbitration
   // ------------------------------------------------------------------

   // The AU writeback belongs to the thread that was in the slot AU_WB_LAT cycles ago.
   always_comb begin
      au_wb_slice = slice_q - AU_LAT;
   end

   // Refuse a load only when it collides with this cycle's AU writeback.
   // A refused load is held by the requester and retried, so the AU
   // pipeline never has to stall. Reset blocks the load so that its data
   // is neither stored nor forwarded while rst is high.
   always_comb begin
      au_ls_conflict = au_rc_vld
                       && (au_wb_slice == ls_wr_slice)
                       && (au_rc_sel   == ls_wr_sel);
      ls_wr_rdy      = !au_ls_conflict;
      ls_wr_en       = ls_wr_vld && !au_ls_conflict && !rst;
   end

   // Decode both write ports into one-hot per-register enables.
   // NOTE: the enables get a full default before any conditional
   // assignment, so no path leaves them unassigned and no latch is inferred.
   always_comb begin
      au_we = '0;
      ls_we = '0;
      if (au_rc_vld) begin
         au_we[au_wb_slice][au_rc_sel] = 1'b1;
      end
      if (ls_wr_en) begin
         ls_we[ls_wr_slice][ls_wr_sel] = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------

   // Register array; both ports may write different entries in the same
   // cycle. The two ports never hit the same entry because the rdy
   // handshake refuses the load in that case.
   // NOTE: the storage is reset, so it is built from flops rather than a
   // RAM macro. A reset must leave every architectural register reading
   // zero, and a RAM cannot be cleared asynchronously in one step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int t = 0; t < NUM_THREADS; t++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
               regs_q[t][r] <= '0;
            end
         end
      end else begin
         for (int t = 0; t < NUM_THREADS; t++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
               if (ls_we[t][r]) begin
                  regs_q[t][r] <= ls_wr_data;
               end else if (au_we[t][r]) begin
                  regs_q[t][r] <= au_rc;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Read ports
   // ------------------------------------------------------------------

   // Pick out the active thread's registers once; all three ports index this row.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         thread_row[r] = regs_q[slice_q][r];
      end
   end

   // A load landing in the active thread this cycle is forwarded to any
   // port reading that register. AU writebacks never need this path.
   always_comb begin
      ra_hit = ls_wr_en && (ls_wr_slice == slice_q) && (ls_wr_sel == au_ra_sel);
      rb_hit = ls_wr_en && (ls_wr_slice == slice_q) && (ls_wr_sel == au_rb_sel);
      ld_hit = ls_wr_en && (ls_wr_slice == slice_q) && (ls_wr_sel == ls_rd_sel);
   end

   // Zero-latency operand and store-data reads for the active thread.
   always_comb begin
      au_ra = bypass_mux(thread_row[au_ra_sel], ra_hit, ls_wr_data);
      au_rb = bypass_mux(thread_row[au_rb_sel], rb_hit, ls_wr_data);
      ls_rd = bypass_mux(thread_row[ls_rd_sel], ld_hit, ls_wr_data);
   end

endmodule
